// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-bit push-button synchroniser and debouncer; BUTTON_DEBOUNCE_EDGE_EN adds press/release pulses
module button_debounce #(
   parameter int   WIDTH        = 4,
   parameter int   SAMPLE_DIV   = 50000,
   parameter int   STABLE_COUNT = 8,
   parameter logic IDLE_LEVEL   = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_buttons,
   output logic [WIDTH-1:0] buttons_out,
   output logic             any_change
`ifdef BUTTON_DEBOUNCE_EDGE_EN
   ,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse
`endif
);

   // SAMPLE_DIV of 1 still needs a 1-bit prescaler that sits at 0 and ticks every cycle.
   localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int CW = $clog2(STABLE_COUNT + 1);

   localparam logic [PW-1:0]    PRE_MAX  = PW'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0]    CNT_MAX  = CW'(STABLE_COUNT - 1);
   localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

   logic [WIDTH-1:0]          sync1;
   logic [WIDTH-1:0]          sync2;
   logic [PW-1:0]             pre_cnt;
   logic                      tick;
   logic [WIDTH-1:0][CW-1:0]  cnt;
   logic [WIDTH-1:0][CW-1:0]  cnt_next;
   logic [WIDTH-1:0]          upd;

   // Two-flop synchroniser; resets to the released level so no phantom press appears after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= IDLE_VEC;
         sync2 <= IDLE_VEC;
      end else begin
         sync1 <= raw_buttons;
         sync2 <= sync1;
      end
   end

   // Free-running sample prescaler shared by all bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick = (pre_cnt == PRE_MAX);

   // Per-bit stability counting: any agreeing sample restarts the count, the last differing one commits.
   always_comb begin
      upd      = '0;
      cnt_next = cnt;
      for (int i = 0; i < WIDTH; i++) begin
         if (tick) begin
            if (sync2[i] == buttons_out[i]) begin
               cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
               cnt_next[i] = '0;
               upd[i]      = 1'b1;
            end else begin
               cnt_next[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   // Counter state, debounced outputs and the change strobe, all updated on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         buttons_out <= IDLE_VEC;
         any_change  <= 1'b0;
      end else begin
         cnt         <= cnt_next;
         buttons_out <= (buttons_out & ~upd) | (sync2 & upd);
         any_change  <= |upd;
      end
   end

`ifdef BUTTON_DEBOUNCE_EDGE_EN
   // Edge pulses: a bit leaving the idle level is a press, returning to it is a release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         press_pulse   <= '0;
         release_pulse <= '0;
      end else begin
         press_pulse   <= upd & ~(buttons_out ^ IDLE_VEC);
         release_pulse <= upd &  (buttons_out ^ IDLE_VEC);
      end
   end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;

   logic       clk;
   logic       reset_n;
   logic [3:0] raw_buttons;
   logic [3:0] buttons_out;
   logic       any_change;
`ifdef BUTTON_DEBOUNCE_EDGE_EN
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
`endif

   int checks = 0;
   int errors = 0;

   button_debounce #(
      .WIDTH        (4),
      .SAMPLE_DIV   (4),
      .STABLE_COUNT (3),
      .IDLE_LEVEL   (1'b1)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .raw_buttons   (raw_buttons),
      .buttons_out   (buttons_out),
      .any_change    (any_change)
`ifdef BUTTON_DEBOUNCE_EDGE_EN
      ,
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset_n     = 1'b0;
      raw_buttons = 4'hF;
      repeat (2) @(negedge clk);
      checks++;
      if (buttons_out !== 4'hF) begin
         errors++;
         $display("FAIL reset_buttons_out got %h want %h", buttons_out, 4'hF);
      end
      checks++;
      if (any_change !== 1'b0) begin
         errors++;
         $display("FAIL reset_any_change got %b want 0", any_change);
      end
      reset_n = 1'b1;
   endtask

   // Starts on the negedge reset is released, so the tick phase is known: change on edge 12.
   task automatic test_press;
      int n;
      n = 0;
      raw_buttons = 4'hE;
      for (int c = 1; c <= 20 && n == 0; c++) begin
         step();
         if (buttons_out !== 4'hF) n = c;
      end
      checks++;
      if (n != 12) begin
         errors++;
         $display("FAIL press_latency got %0d want 12", n);
      end
      checks++;
      if (buttons_out !== 4'hE) begin
         errors++;
         $display("FAIL press_value got %h want %h", buttons_out, 4'hE);
      end
      checks++;
      if (any_change !== 1'b1) begin
         errors++;
         $display("FAIL press_any_change got %b want 1", any_change);
      end
`ifdef BUTTON_DEBOUNCE_EDGE_EN
      checks++;
      if (press_pulse !== 4'b0001 || release_pulse !== 4'b0000) begin
         errors++;
         $display("FAIL press_pulses got %b/%b want 0001/0000", press_pulse, release_pulse);
      end
`endif
      step();
      checks++;
      if (any_change !== 1'b0 || buttons_out !== 4'hE) begin
         errors++;
         $display("FAIL press_after got %b/%h want 0/%h", any_change, buttons_out, 4'hE);
      end
`ifdef BUTTON_DEBOUNCE_EDGE_EN
      checks++;
      if (press_pulse !== 4'b0000) begin
         errors++;
         $display("FAIL press_pulse_width got %b want 0000", press_pulse);
      end
`endif
   endtask

   task automatic test_release;
      int n;
      n = 0;
      raw_buttons = 4'hF;
      for (int c = 1; c <= 20 && n == 0; c++) begin
         step();
         if (buttons_out !== 4'hE) n = c;
      end
      checks++;
      if (n < 11 || n > 14) begin
         errors++;
         $display("FAIL release_latency got %0d want 11..14", n);
      end
      checks++;
      if (buttons_out !== 4'hF || any_change !== 1'b1) begin
         errors++;
         $display("FAIL release_value got %h/%b want %h/1", buttons_out, any_change, 4'hF);
      end
`ifdef BUTTON_DEBOUNCE_EDGE_EN
      checks++;
      if (release_pulse !== 4'b0001 || press_pulse !== 4'b0000) begin
         errors++;
         $display("FAIL release_pulses got %b/%b want 0001/0000", release_pulse, press_pulse);
      end
`endif
      step();
      checks++;
      if (any_change !== 1'b0) begin
         errors++;
         $display("FAIL release_any_change_width got %b want 0", any_change);
      end
   endtask

   // Each value is held exactly one tick period, so every tick sees one sample: 0,0,1 never reaches 3.
   task automatic test_bounce;
      logic [2:0] pat;
      pat = 3'b100;
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) begin
            raw_buttons = pat[k] ? 4'hF : 4'hD;
            for (int c = 0; c < 4; c++) begin
               step();
               checks++;
               if (buttons_out !== 4'hF || any_change !== 1'b0) begin
                  errors++;
                  $display("FAIL bounce r%0d k%0d got %h/%b want %h/0", r, k, buttons_out, any_change, 4'hF);
               end
            end
         end
      end
      raw_buttons = 4'hF;
      repeat (16) step();
      checks++;
      if (buttons_out !== 4'hF) begin
         errors++;
         $display("FAIL bounce_settle got %h want %h", buttons_out, 4'hF);
      end
   endtask

   task automatic test_simultaneous;
      int n;
      int pulses;
      n = 0;
      pulses = 0;
      raw_buttons = 4'h3;
      for (int c = 1; c <= 20 && n == 0; c++) begin
         step();
         if (any_change === 1'b1) pulses++;
         if (buttons_out !== 4'hF) n = c;
      end
      checks++;
      if (n < 11 || n > 14) begin
         errors++;
         $display("FAIL simul_latency got %0d want 11..14", n);
      end
      checks++;
      if (buttons_out !== 4'h3) begin
         errors++;
         $display("FAIL simul_value got %h want %h", buttons_out, 4'h3);
      end
`ifdef BUTTON_DEBOUNCE_EDGE_EN
      checks++;
      if (press_pulse !== 4'b1100) begin
         errors++;
         $display("FAIL simul_press_pulse got %b want 1100", press_pulse);
      end
`endif
      for (int c = 0; c < 8; c++) begin
         step();
         if (any_change === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL simul_any_change_count got %0d want 1", pulses);
      end
      raw_buttons = 4'hF;
      n = 0;
      for (int c = 1; c <= 20 && n == 0; c++) begin
         step();
         if (buttons_out !== 4'h3) n = c;
      end
      checks++;
      if (buttons_out !== 4'hF) begin
         errors++;
         $display("FAIL simul_restore got %h want %h", buttons_out, 4'hF);
      end
`ifdef BUTTON_DEBOUNCE_EDGE_EN
      checks++;
      if (release_pulse !== 4'b1100) begin
         errors++;
         $display("FAIL simul_release_pulse got %b want 1100", release_pulse);
      end
`endif
      step();
   endtask

   task automatic test_reset_mid_count;
      int early;
      early = 0;
      raw_buttons = 4'h7;
      repeat (9) step();
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (buttons_out !== 4'hF || any_change !== 1'b0) begin
         errors++;
         $display("FAIL midreset_assert got %h/%b want %h/0", buttons_out, any_change, 4'hF);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         step();
         if (buttons_out !== 4'hF) early++;
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL midreset_early got %0d changed cycles want 0", early);
      end
      step();
      checks++;
      if (buttons_out !== 4'h7 || any_change !== 1'b1) begin
         errors++;
         $display("FAIL midreset_commit got %h/%b want %h/1", buttons_out, any_change, 4'h7);
      end
      // Reset between clock edges while any_change is high: both must clear at once.
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (buttons_out !== 4'hF || any_change !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got %h/%b want %h/0", buttons_out, any_change, 4'hF);
      end
`ifdef BUTTON_DEBOUNCE_EDGE_EN
      checks++;
      if (press_pulse !== 4'b0000 || release_pulse !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset_pulses got %b/%b want 0000/0000", press_pulse, release_pulse);
      end
`endif
      @(negedge clk);
      raw_buttons = 4'hF;
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_press();
      test_release();
      test_bounce();
      test_simultaneous();
      test_reset_mid_count();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Upstream conditioning stage for the Nios II buttons PIO.
- Synchronises the raw DE10 push-button pins to clk and debounces each bit independently with a shared sample prescaler.
- Drives the PIO's 4-bit in_port with clean, glitch-free levels.
- Sits between the top-level KEY pins and the PIO input; software sees only settled button states.

Parameters:
- WIDTH, 4, number of buttons (bits).
- SAMPLE_DIV, 50000, clk cycles per sample tick (1 ms at 50 MHz); legal range >= 1, where 1 means a tick every cycle.
- STABLE_COUNT, 8, consecutive differing sample ticks required before the output follows; legal range >= 1.
- IDLE_LEVEL, 1, level of a released button (DE10 KEYs are active-low); also the reset value of every output bit.

Ports:
- clk  input  1  system clock, shared with the PIO.
- reset_n  input  1  asynchronous active-low reset.
- raw_buttons  input  WIDTH  unsynchronised button pins.
- buttons_out  output  WIDTH  debounced levels, same polarity as raw_buttons; connects to PIO in_port.
- any_change  output  1  one-cycle pulse when any bit of buttons_out changed this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low. All flops clear immediately on reset_n=0, regardless of clk.
- Reset values:
  - buttons_out = {WIDTH{IDLE_LEVEL}}
  - any_change = 0
  - synchroniser flops = IDLE_LEVEL
  - prescaler = 0
  - all per-bit counters = 0
- Synchroniser: 2 flops per bit; sync[i] is raw_buttons[i] delayed 2 cycles.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1 and wraps to 0.
  - tick is high for the single cycle where the count equals SAMPLE_DIV-1.
  - Free-running, independent of button activity.
- Per-bit counter (width clog2(STABLE_COUNT+1)), updated only on tick cycles; holds between ticks:
  - If sync[i] == buttons_out[i]: counter cleared to 0. This is glitch rejection; one agreeing sample restarts the count.
  - If sync[i] != buttons_out[i] and counter == STABLE_COUNT-1: buttons_out[i] <= sync[i] and the counter clears.
  - Otherwise: counter increments.
- Net rule: the output changes on the STABLE_COUNT-th consecutive tick that sees a differing synchronised value.
- Latency from a raw edge to output: 2 cycles + between (STABLE_COUNT-1)*SAMPLE_DIV+1 and STABLE_COUNT*SAMPLE_DIV cycles.
- Simultaneous changes: bits are fully independent. Multiple bits may update in the same tick cycle.
- any_change:
  - Registered; high for exactly 1 cycle, in the same cycle buttons_out updates.
  - Equivalent to OR of per-bit update strobes.
- No combinational path from raw_buttons to any output. All outputs are flop-driven.
- Reset asserted mid-count: the partial count is lost. After release, a full STABLE_COUNT ticks are required again.
- Prescaler phase after reset: the first tick occurs SAMPLE_DIV cycles after reset_n deasserts.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_EDGE_EN.
- Defined: adds two output ports, both registered, both zero at reset, and both asserted in the same cycle buttons_out changes.
  - press_pulse [WIDTH]: one-cycle pulse per bit on an IDLE_LEVEL -> !IDLE_LEVEL transition of buttons_out.
  - release_pulse [WIDTH]: one-cycle pulse per bit on the opposite transition.
- Undefined: both ports and their logic are absent. buttons_out and any_change behave identically in either case.

Test Plan (SAMPLE_DIV=4, STABLE_COUNT=3, WIDTH=4, IDLE_LEVEL=1):
- Reset: raw=4'hF, pulse reset_n low mid-cycle -> buttons_out=4'hF and any_change=0 asynchronously; first tick 4 cycles after release.
- Clean press: raw 4'hF -> 4'hE held -> buttons_out=4'hE on the 3rd tick after sync shows 0 (within 14 cycles); any_change=1 for 1 cycle; press_pulse=4'b0001 for 1 cycle (EDGE_EN).
- Bounce: raw bit1 pattern 0,0,1 per tick, repeated 10 times -> buttons_out bit1 stays 1; any_change never asserts.
- Simultaneous: raw 4'hF -> 4'h3 in one cycle -> bits 2 and 3 update in the same cycle; press_pulse=4'b1100; single any_change pulse.
- Release: from 4'hE, raw -> 4'hF -> buttons_out=4'hF after 3 ticks; release_pulse=4'b0001; press_pulse=0.
- Reset mid-count: raw=4'h7, assert reset after 2 ticks, release with raw still 4'h7 -> buttons_out stays 4'hF until 3 full ticks after release, then 4'h7.
